// File: rtl/oserdes_rx_pkg.sv
// Shared definitions for the byte serial link (transmit and receive sides).
// Frame length width must match between length_in and frame_len_o.
package oserdes_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned FRAME_LEN_W    = 8;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } rx_state_e;

    function automatic logic [FRAME_LEN_W-1:0] sat_inc(input logic [FRAME_LEN_W-1:0] v);
        return (v == '1) ? v : v + FRAME_LEN_W'(1);
    endfunction

endpackage

// File: rtl/oserdes_rx_fifo.sv
// Single-clock show-ahead FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo_fwft #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                     (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    // Pop on empty is ignored, so a simultaneous push still lands.
    assign w_pop   = pop_i && !w_empty;
    assign w_push  = push_i && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= push_data_i;
    end

    assign data_o  = w_empty ? '0 : r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign valid_o = !w_empty;
    assign full_o  = w_full;
    assign count_o = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/oserdes_rx.sv
// Serial link receiver: LSB-first bit reassembly, valid-delimited framing,
// byte buffering with frame length / truncation / overflow reporting.
module oserdes_rx
    import oserdes_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bit_i,
    input  logic                   valid_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   data_valid_o,
    input  logic                   data_ready_i,
    output logic [ADDR_WIDTH:0]    fifo_count_o,
    output logic                   frame_done_o,
    output logic [FRAME_LEN_W-1:0] frame_len_o,
    output logic                   frame_err_o,
    output logic                   overflow_o,
    input  logic                   overflow_clr_i
);

    localparam int unsigned        CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e              r_state;
    rx_state_e              w_state_next;
    logic [DATA_WIDTH-2:0]  r_shreg;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [FRAME_LEN_W-1:0] r_byte_cnt;
    logic [FRAME_LEN_W-1:0] r_frame_len;
    logic                   r_frame_done;
    logic                   r_frame_err;
    logic                   r_overflow;
    logic                   w_start;
    logic                   w_shift;
    logic                   w_frame_end;
    logic                   w_byte_done;
    logic                   w_full;
    logic                   w_drop;
    logic [DATA_WIDTH-1:0]  w_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= StIdle;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (valid_i)  w_state_next = StShift;
            StShift: if (!valid_i) w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            StIdle:  w_start = valid_i;
            StShift: begin
                w_shift     = valid_i;
                w_frame_end = !valid_i;
            end
        endcase
    end

    assign w_byte_done = w_shift && (r_bit_cnt == LAST_BIT);
    assign w_byte      = {bit_i, r_shreg};
    // Full implies non-empty, so data_ready_i alone means a pop frees a slot.
    assign w_drop      = w_byte_done && w_full && !data_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_frame_err  <= w_frame_end && (r_bit_cnt != '0);
            if (w_frame_end) r_frame_len <= r_byte_cnt;
            if (w_start) begin
                r_shreg    <= {{(DATA_WIDTH-2){1'b0}}, bit_i};
                r_bit_cnt  <= CNT_W'(1);
                r_byte_cnt <= '0;
            end else if (w_shift) begin
                if (w_byte_done) begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= sat_inc(r_byte_cnt);
                end else begin
                    r_shreg[r_bit_cnt] <= bit_i;
                    r_bit_cnt          <= r_bit_cnt + CNT_W'(1);
                end
            end
            if (w_drop)              r_overflow <= 1'b1;
            else if (overflow_clr_i) r_overflow <= 1'b0;
        end
    end

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_byte_done),
        .push_data_i (w_byte),
        .pop_i       (data_ready_i),
        .data_o      (data_o),
        .valid_o     (data_valid_o),
        .full_o      (w_full),
        .count_o     (fifo_count_o)
    );

    assign frame_done_o = r_frame_done;
    assign frame_err_o  = r_frame_err;
    assign frame_len_o  = r_frame_len;
    assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_oserdes_rx.sv
// Scoreboard bench for oserdes_rx: stimulus queues expected bytes and frame
// reports, a negedge monitor pops and compares whenever the DUT presents them.
module tb_oserdes_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       data_ready_i = 1'b0;
    logic       overflow_clr_i = 1'b0;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic [4:0] fifo_count_o;
    logic       frame_done_o;
    logic [7:0] frame_len_o;
    logic       frame_err_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    logic [8:0] frm_q[$];

    always #5 clk = ~clk;

    oserdes_rx u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bit_i          (bit_i),
        .valid_i        (valid_i),
        .data_o         (data_o),
        .data_valid_o   (data_valid_o),
        .data_ready_i   (data_ready_i),
        .fifo_count_o   (fifo_count_o),
        .frame_done_o   (frame_done_o),
        .frame_len_o    (frame_len_o),
        .frame_err_o    (frame_err_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected", name);
    endtask

    // Monitor: byte pops and frame reports against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (data_valid_o && data_ready_i) begin
                if (exp_q.size() == 0) fail_evt("pop_unexpected");
                else chk("pop_data", int'(data_o), int'(exp_q.pop_front()));
            end
            if (frame_done_o) begin
                if (frm_q.size() == 0) begin
                    fail_evt("frame_done_unexpected");
                end else begin
                    logic [8:0] f;
                    f = frm_q.pop_front();
                    chk("frame_len", int'(frame_len_o), int'(f[7:0]));
                    chk("frame_err", int'(frame_err_o), int'(f[8]));
                end
            end else if (frame_err_o) begin
                fail_evt("frame_err_without_done");
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        bit_i   = b;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit expect_it);
        if (expect_it) exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic end_frame(input int len, input bit err);
        frm_q.push_back({err, 8'(len)});
        valid_i = 1'b0;
        bit_i   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        data_ready_i = 1'b1;
        for (int i = 0; i < 100 && fifo_count_o != 0; i++) idle(1);
        chk(name, int'(fifo_count_o), 0);
        data_ready_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_data_valid"}, int'(data_valid_o), 0);
        chk({tag, "_data"}, int'(data_o), 0);
        chk({tag, "_count"}, int'(fifo_count_o), 0);
        chk({tag, "_frame_done"}, int'(frame_done_o), 0);
        chk({tag, "_frame_len"}, int'(frame_len_o), 0);
        chk({tag, "_frame_err"}, int'(frame_err_o), 0);
        chk({tag, "_overflow"}, int'(overflow_o), 0);
    endtask

    initial begin
        logic [7:0] v;

        #12;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // 1: single byte 0xA5, one clock to data_o
        v = 8'hA5;
        exp_q.push_back(v);
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        @(negedge clk);
        chk("t1_valid_before_8th", int'(data_valid_o), 0);
        send_bit(v[7]);
        @(negedge clk);
        chk("t1_valid", int'(data_valid_o), 1);
        chk("t1_data", int'(data_o), 8'hA5);
        chk("t1_count", int'(fifo_count_o), 1);
        end_frame(1, 1'b0);
        drain("t1_drain");
        idle(2);

        // 2: back-to-back bytes, consumer always ready
        data_ready_i = 1'b1;
        send_byte(8'h01, 1'b1);
        send_byte(8'h80, 1'b1);
        @(negedge clk);
        chk("t2_head_data", int'(data_o), 8'h80);
        chk("t2_head_count", int'(fifo_count_o), 1);
        send_byte(8'hFF, 1'b1);
        end_frame(3, 1'b0);
        idle(2);
        chk("t2_empty", int'(fifo_count_o), 0);
        data_ready_i = 1'b0;
        idle(2);

        // 3: truncated frame, 0x5A then a half byte
        send_byte(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        end_frame(1, 1'b1);
        chk("t3_count", int'(fifo_count_o), 1);
        drain("t3_drain");
        idle(2);

        // 4: overflow, 17 bytes into a 16-entry buffer
        for (int i = 0; i < 17; i++) send_byte(8'(i), i < 16);
        end_frame(17, 1'b0);
        chk("t4_count_full", int'(fifo_count_o), 16);
        chk("t4_overflow_set", int'(overflow_o), 1);
        drain("t4_drain");
        chk("t4_overflow_sticky", int'(overflow_o), 1);
        overflow_clr_i = 1'b1;
        idle(1);
        overflow_clr_i = 1'b0;
        chk("t4_overflow_clr", int'(overflow_o), 0);
        idle(2);

        // 5: full buffer, pop coincides with the 8th bit of a new byte
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
        end_frame(16, 1'b0);
        chk("t5_count_full", int'(fifo_count_o), 16);
        v = 8'h77;
        exp_q.push_back(v);
        for (int i = 0; i < 7; i++) send_bit(v[i]);
        data_ready_i = 1'b1;
        send_bit(v[7]);
        data_ready_i = 1'b0;
        end_frame(1, 1'b0);
        chk("t5_count_kept", int'(fifo_count_o), 16);
        chk("t5_no_overflow", int'(overflow_o), 0);
        drain("t5_drain");
        idle(2);

        // 6: reset during bit 4 of the second byte of a frame
        send_byte(8'h11, 1'b0);
        chk("t6_pre_count", int'(fifo_count_o), 1);
        v = 8'hC3;
        for (int i = 0; i < 4; i++) send_bit(v[i]);
        bit_i = v[4];
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("t6_async");
        valid_i = 1'b0;
        exp_q.delete();
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk("t6_no_done", int'(frame_len_o), 0);
        send_byte(8'h3C, 1'b1);
        end_frame(1, 1'b0);
        drain("t6_drain");
        idle(3);

        chk("end_bytes_pending", exp_q.size(), 0);
        chk("end_frames_pending", frm_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
